// File: rtl/multu_hilo_if.sv
// Operand, function-code and readback bus between the ALU control block and multu_hilo.
interface multu_hilo_if #(
   parameter int WIDTH = 32
);
   logic [5:0]       Signal;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [WIDTH-1:0] dataOut;
   logic             busy;

   modport master (output Signal, output dataA, output dataB, input dataOut, input busy);
   modport slave  (input Signal, input dataA, input dataB, output dataOut, output busy);
endinterface

// File: rtl/multu_hilo.sv
// Sequential shift-add unsigned multiplier with HI/LO result registers.
// Optional MULTU_AUTO_COMMIT_EN: commit HI/LO at the last iteration instead of waiting for HILO_WR.
module multu_hilo #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst_n,
   multu_hilo_if.slave bus
);
   localparam logic [5:0] SIG_MULTU   = 6'b011001;
   localparam logic [5:0] SIG_MFHI    = 6'b010000;
   localparam logic [5:0] SIG_MFLO    = 6'b010010;
   localparam logic [5:0] SIG_HILO_WR = 6'b111111;
   localparam logic [5:0] CNT_LAST    = 6'(WIDTH - 1);
   localparam int         PW          = 2 * WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [5:0]       sig_q, sig_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [PW-1:0]    step_s;
   logic [WIDTH:0]   upper_s;
   logic             start_s;
   logic             last_s;

   // One shift-add iteration; prod_q's top bit is always clear, so the sum cannot overflow W+1 bits.
   always_comb begin
      if (prod_q[0]) begin
         upper_s = prod_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
      end else begin
         upper_s = prod_q[2*WIDTH:WIDTH];
      end
      step_s  = {1'b0, upper_s, prod_q[WIDTH-1:1]};
      start_s = (bus.Signal == SIG_MULTU) && (sig_q != SIG_MULTU);
      last_s  = (cnt_q == CNT_LAST);
   end

   // Next-state and register update logic.
   always_comb begin
      state_d = state_q;
      sig_d   = bus.Signal;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               mcand_d = bus.dataA;
               prod_d  = {{(WIDTH+1){1'b0}}, bus.dataB};
               cnt_d   = 6'd0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            prod_d = step_s;
            cnt_d  = cnt_q + 6'd1;
            if (last_s) begin
`ifdef MULTU_AUTO_COMMIT_EN
               hi_d    = step_s[2*WIDTH-1:WIDTH];
               lo_d    = step_s[WIDTH-1:0];
               state_d = S_IDLE;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
`ifdef MULTU_AUTO_COMMIT_EN
            state_d = S_IDLE;
`else
            // A fresh MULTU edge here is deliberately ignored until the product is committed.
            if (bus.Signal == SIG_HILO_WR) begin
               hi_d    = prod_q[2*WIDTH-1:WIDTH];
               lo_d    = prod_q[WIDTH-1:0];
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sig_q   <= 6'b000000;
         cnt_q   <= 6'd0;
         mcand_q <= {WIDTH{1'b0}};
         prod_q  <= {PW{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Readback mux from the committed HI/LO registers.
   always_comb begin
      case (bus.Signal)
         SIG_MFHI: bus.dataOut = hi_q;
         SIG_MFLO: bus.dataOut = lo_q;
         default:  bus.dataOut = {WIDTH{1'b0}};
      endcase
   end

   assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_multu_hilo.sv
// Table-driven bench for multu_hilo with a scoreboard queue of expected {HI,LO} products.
module tb_multu_hilo;
   localparam logic [5:0] SIG_NONE    = 6'b000000;
   localparam logic [5:0] SIG_MULTU   = 6'b011001;
   localparam logic [5:0] SIG_MFHI    = 6'b010000;
   localparam logic [5:0] SIG_MFLO    = 6'b010010;
   localparam logic [5:0] SIG_HILO_WR = 6'b111111;
`ifdef MULTU_AUTO_COMMIT_EN
   localparam int BUSY_EXP = 32;
`else
   localparam int BUSY_EXP = 33;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      bit          peek;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   logic [31:0] hi_model;
   logic [31:0] lo_model;
   logic [63:0] sb_q[$];
   vec_t vecs[8];

   multu_hilo_if #(.WIDTH(32)) bus();

   multu_hilo #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
      bus.Signal = sig;
      bus.dataA  = a;
      bus.dataB  = b;
   endtask

   // Pop the next expected product and read it back through MFLO/MFHI.
   task automatic readback(input string name);
      logic [63:0] exp;
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, 64'd1, 64'd0);
         return;
      end
      exp = sb_q.pop_front();
      hi_model = exp[63:32];
      lo_model = exp[31:0];
      bus.Signal = SIG_MFLO;
      #1 check({name, "_lo"}, {32'd0, bus.dataOut}, {32'd0, lo_model});
      bus.Signal = SIG_MFHI;
      #1 check({name, "_hi"}, {32'd0, bus.dataOut}, {32'd0, hi_model});
      bus.Signal = SIG_NONE;
      #1 check({name, "_other_code"}, {32'd0, bus.dataOut}, 64'd0);
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit peek);
      int busy_cycles;
      drive(SIG_NONE, a, b);
      step();
      drive(SIG_MULTU, a, b);
      sb_q.push_back(exp);
      step();
      busy_cycles = 0;
      for (int i = 1; i <= 32; i++) begin
         if (bus.busy) busy_cycles++;
         bus.dataA = ~a;
         bus.dataB = b ^ 32'h5A5A5A5A;
         if (peek && i == 5) begin
            bus.Signal = SIG_MFHI;
            #1 check({name, "_hi_before_commit"}, {32'd0, bus.dataOut}, {32'd0, hi_model});
         end else begin
            bus.Signal = SIG_MULTU;
         end
         step();
      end
`ifdef MULTU_AUTO_COMMIT_EN
      check({name, "_busy_after_e32"}, {63'd0, bus.busy}, 64'd0);
      readback(name);
      drive(SIG_HILO_WR, a, b);
      step();
      step();
      bus.Signal = SIG_MFLO;
      #1 check({name, "_lo_after_late_wr"}, {32'd0, bus.dataOut}, {32'd0, lo_model});
      bus.Signal = SIG_MFHI;
      #1 check({name, "_hi_after_late_wr"}, {32'd0, bus.dataOut}, {32'd0, hi_model});
`else
      if (bus.busy) busy_cycles++;
      bus.Signal = SIG_HILO_WR;
      step();
      check({name, "_busy_after_commit"}, {63'd0, bus.busy}, 64'd0);
      readback(name);
`endif
      check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(BUSY_EXP));
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      hi_model = 32'd0;
      lo_model = 32'd0;
      vecs[0] = '{32'd3,          32'd5,          64'h00000000_0000000F, 1'b0};
      vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, 1'b0};
      vecs[2] = '{32'h80000000,   32'd2,          64'h00000001_00000000, 1'b1};
      vecs[3] = '{32'd7,          32'd9,          64'h00000000_0000003F, 1'b0};
      vecs[4] = '{32'd0,          32'h12345678,   64'h00000000_00000000, 1'b0};
      vecs[5] = '{32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0};
      vecs[6] = '{32'h00010000,   32'h00010000,   64'h00000001_00000000, 1'b1};
      vecs[7].a = $urandom;
      vecs[7].b = $urandom;
      vecs[7].p = 64'(vecs[7].a) * 64'(vecs[7].b);
      vecs[7].peek = 1'b0;

      rst_n = 1'b0;
      drive(SIG_MFHI, 32'hDEADBEEF, 32'hCAFEF00D);
      step();
      step();
      check("reset_busy", {63'd0, bus.busy}, 64'd0);
      check("reset_hi", {32'd0, bus.dataOut}, 64'd0);
      bus.Signal = SIG_MFLO;
      #1 check("reset_lo", {32'd0, bus.dataOut}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("idle_busy", {63'd0, bus.busy}, 64'd0);

      for (int v = 0; v < 8; v++) begin
         run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].peek);
      end

      // MULTU held for 40 cycles must run exactly one operation on the E0 operands.
      begin
         int busy_cycles;
         drive(SIG_NONE, 32'd11, 32'd13);
         step();
         drive(SIG_MULTU, 32'd11, 32'd13);
         sb_q.push_back(64'd143);
         step();
         bus.dataA = 32'd1000;
         bus.dataB = 32'd1000;
         busy_cycles = 0;
         for (int i = 1; i <= 39; i++) begin
            if (bus.busy) busy_cycles++;
            step();
         end
`ifdef MULTU_AUTO_COMMIT_EN
         check("held_busy_cycles", 64'(busy_cycles), 64'd32);
         check("held_busy_end", {63'd0, bus.busy}, 64'd0);
`else
         if (bus.busy) busy_cycles++;
         check("held_busy_cycles", 64'(busy_cycles), 64'd40);
         bus.Signal = SIG_HILO_WR;
         step();
`endif
         bus.Signal = SIG_MFLO;
         step();
         step();
         check("held_busy_after", {63'd0, bus.busy}, 64'd0);
         readback("held");
      end

      // Asynchronous reset at iteration 10 aborts the operation and clears HI/LO.
      drive(SIG_NONE, 32'h1234, 32'h5678);
      step();
      drive(SIG_MULTU, 32'h1234, 32'h5678);
      step();
      for (int i = 1; i <= 10; i++) step();
      #2 rst_n = 1'b0;
      bus.Signal = SIG_MFHI;
      #1 check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_mid_hi", {32'd0, bus.dataOut}, 64'd0);
      bus.Signal = SIG_MFLO;
      #1 check("rst_mid_lo", {32'd0, bus.dataOut}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hi_model = 32'd0;
      lo_model = 32'd0;
      bus.Signal = SIG_HILO_WR;
      for (int i = 0; i < 30; i++) step();
      bus.Signal = SIG_MFLO;
      #1 check("rst_no_commit_lo", {32'd0, bus.dataOut}, 64'd0);
      check("rst_no_commit_busy", {63'd0, bus.busy}, 64'd0);
      run_op("after_rst", 32'h0000FFFF, 32'h00010001, 64'h00000000_FFFFFFFF, 1'b1);

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
